// File: rtl/serial_alu_ctrl_pkg.sv
// Shared ALU definitions: controller state encoding and op-select constants.
package serial_alu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Command/result bus between the ALU operand source and the serial controller.
interface serial_alu_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/serial_alu_ctrl_fa.sv
// One-bit full-adder cell; the only arithmetic in the serial datapath.
module serial_alu_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum_c,
   output logic cout_c
);

   // Sum and carry of three input bits
   always_comb begin
      sum_c  = a ^ b ^ cin;
      cout_c = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial add/subtract controller: sequences one full-adder cell LSB first
// over WIDTH clocks and returns a registered result with carry/overflow.
module serial_alu_ctrl
   import serial_alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_alu_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   alu_state_e       state;
   alu_state_e       state_nxt;
   logic             load_c;
   logic             last_c;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] shreg;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic             fa_sum;
   logic             fa_cout;

   serial_alu_ctrl_fa u_fa (
      .a      (op_a[0]),
      .b      (op_b[0]),
      .cin    (carry),
      .sum_c  (fa_sum),
      .cout_c (fa_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus load/finish strobes for the datapath
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      last_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load_c    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, serial shift loop and result/flag capture on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         shreg    <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (load_c) begin
         op_a  <= bus.a;
         op_b  <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
         carry <= (bus.sub == OP_SUB);
         cnt   <= '0;
      end else if (state == RUN) begin
         shreg <= {fa_sum, shreg[WIDTH-1:1]};
         op_a  <= {1'b0, op_a[WIDTH-1:1]};
         op_b  <= {1'b0, op_b[WIDTH-1:1]};
         carry <= fa_cout;
         cnt   <= cnt + CNT_W'(1);
         if (last_c) begin
            // carry still holds the carry into the MSB on this edge
            result_q <= {fa_sum, shreg[WIDTH-1:1]};
            cout_q   <= fa_cout;
            ovf_q    <= carry ^ fa_cout;
         end
      end
   end

   // Moore status flags, registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt == RUN);
         done_q <= (state_nxt == DONE);
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with a result scoreboard.
module tb_serial_alu_ctrl;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_alu_ctrl_if #(.WIDTH(W)) bus ();

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] last_res = 8'h00;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: A + (sub ? ~B : B) + sub, flags from sign bits
   function automatic exp_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] yb;
      logic [8:0] sm;
      exp_t       e;
      yb    = s ? ~y : y;
      sm    = {1'b0, x} + {1'b0, yb} + 9'(s);
      e.res = sm[7:0];
      e.c   = sm[8];
      e.v   = (x[7] == yb[7]) && (sm[7] != x[7]);
      return e;
   endfunction

   task automatic check_out();
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("result", 32'(bus.result), 32'(e.res));
         chk("cout", 32'(bus.cout), 32'(e.c));
         chk("ovf", 32'(bus.ovf), 32'(e.v));
         last_res = e.res;
      end
   endtask

   // Issue one op and follow it to done; leaves the bench in the IDLE cycle after DONE
   task automatic do_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int nbusy);
      sb.push_back(model(s, x, y));
      bus.start = 1'b1;
      bus.sub   = s;
      bus.a     = x;
      bus.b     = y;
      step();
      bus.start = 1'b0;
      lat   = -1;
      nbusy = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.busy) begin
            nbusy++;
            chk("result_held_in_run", 32'(bus.result), 32'(last_res));
         end
         chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
         if (bus.done) begin
            lat = c;
            check_out();
            break;
         end
         step();
      end
      step();
   endtask

   initial begin
      int lat;
      int nbusy;
      int ndone;
      int last_done;
      int accept_at;
      int nxt;
      logic [7:0] xs[3];
      logic [7:0] ys[3];

      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      step();

      // 0x5A + 0x3C: timing and overflow
      do_op(1'b0, 8'h5A, 8'h3C, lat, nbusy);
      chk("lat_5a3c", 32'(lat), 32'd9);
      chk("busy_cycles_5a3c", 32'(nbusy), 32'd8);
      chk("res_5a3c_const", 32'(bus.result), 32'h96);

      do_op(1'b0, 8'hFF, 8'h01, lat, nbusy);
      chk("lat_ff01", 32'(lat), 32'd9);
      do_op(1'b1, 8'h10, 8'h20, lat, nbusy);
      chk("lat_sub1020", 32'(lat), 32'd9);

      // start pulses during RUN and DONE are ignored
      sb.push_back(model(1'b0, 8'h33, 8'h44));
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h33; bus.b = 8'h44;
      step();
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      step(); step(); step();
      bus.start = 1'b1; bus.sub = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
      step();
      bus.start = 1'b0;
      lat = -1;
      for (int c = 5; c <= 40; c++) begin
         if (bus.done) begin
            lat = c;
            check_out();
            break;
         end
         step();
      end
      chk("lat_ignore_run", 32'(lat), 32'd9);
      bus.start = 1'b1; bus.a = 8'hEE; bus.b = 8'h11;
      step();
      bus.start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         chk("ignore_busy", 32'(bus.busy), 32'd0);
         chk("ignore_done", 32'(bus.done), 32'd0);
         step();
      end
      chk("ignore_result_kept", 32'(bus.result), 32'h77);

      do_op(1'b1, 8'h80, 8'h01, lat, nbusy);
      chk("lat_sub8001", 32'(lat), 32'd9);

      // asynchronous reset at bit 4 of a run
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h12; bus.b = 8'h34;
      step();
      bus.start = 1'b0;
      for (int c = 0; c < 4; c++) step();
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_result", 32'(bus.result), 32'd0);
      chk("arst_cout", 32'(bus.cout), 32'd0);
      chk("arst_ovf", 32'(bus.ovf), 32'd0);
      last_res = 8'h00;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk("post_rst_no_done", 32'(bus.done), 32'd0);
         step();
      end
      do_op(1'b0, 8'h01, 8'h01, lat, nbusy);
      chk("lat_0101", 32'(lat), 32'd9);
      chk("res_0101_const", 32'(bus.result), 32'h02);

      // start held high: three back-to-back adds
      xs[0] = 8'h11; xs[1] = 8'h7F; xs[2] = 8'hC8;
      ys[0] = 8'h22; ys[1] = 8'h01; ys[2] = 8'h64;
      for (int i = 0; i < 3; i++) sb.push_back(model(1'b0, xs[i], ys[i]));
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = xs[0]; bus.b = ys[0];
      step();
      bus.a = xs[1]; bus.b = ys[1];
      nxt = 2; ndone = 0; last_done = -1; accept_at = -1;
      for (int c = 1; c <= 60 && ndone < 3; c++) begin
         if (c == accept_at && nxt < 3) begin
            bus.a = xs[nxt];
            bus.b = ys[nxt];
            nxt++;
         end
         if (bus.busy) chk("b2b_result_held", 32'(bus.result), 32'(last_res));
         chk("b2b_busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
         if (bus.done) begin
            check_out();
            if (last_done >= 0) chk("b2b_interval", 32'(c - last_done), 32'd10);
            else chk("b2b_first_lat", 32'(c), 32'd9);
            last_done = c;
            ndone++;
            accept_at = c + 2;
            if (ndone == 3) bus.start = 1'b0;
         end
         step();
      end
      chk("b2b_done_count", 32'(ndone), 32'd3);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first. It sits between the simple ALU's operand/command source and the one-bit adder datapath. It captures operands on a start handshake, sequences the cell with a registered carry loop, and returns a registered result with carry and signed-overflow flags. Area-minimal alternative to the ripple adder for the simple ALU.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while serial bits are being computed (RUN).
- done  output  1  one-cycle pulse: result/flags just updated.
- result  output  WIDTH  sum/difference, held until next completion.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: if start=1, then at the edge load opA←a, opB←(sub ? ~b : b), carry←sub, bit counter←0, and enter RUN. start=0 stays in IDLE.
- RUN: the cell adds opA[0], opB[0], and carry each cycle. At each edge:
  - the sum bit shifts into the MSB of an internal shift register (shift right);
  - opA and opB shift right;
  - carry←cell carry out;
  - counter increments.
- On the edge where counter = WIDTH−1, the prior carry (carry into MSB) is kept for ovf.
- Leaving RUN (counter = WIDTH−1): result←final shift-register value, cout←cell carry out, ovf←carry-into-MSB XOR cell carry out, and enter DONE.
- DONE: done=1 for exactly one cycle, then unconditionally → IDLE. start during DONE is ignored.
- start during RUN is ignored; operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- result, cout, and ovf change only on the edge entering DONE. They are stable at all other times, including during a following RUN.
- Reset at any time, including mid-RUN: state→IDLE, busy=0, done=0, result=0, cout=0, ovf=0, and internal registers are cleared. The aborted operation produces no done.

## Timing
- start sampled high at edge k (state IDLE):
  - busy high in cycles k+1 … k+WIDTH;
  - done high in cycle k+WIDTH+1;
  - result valid from cycle k+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles. Minimum issue interval is WIDTH+2 cycles.
- With start held high continuously, the next operation is accepted at the edge ending the IDLE cycle after DONE.
- busy and done are never high in the same cycle. Both are registered, Moore-decoded from state.

## Structure
- Shared ALU package: state encoding enum (IDLE/RUN/DONE) and the op-select constants (OP_ADD=0, OP_SUB=1).
- One sub-module, the existing one-bit full-adder cell FA (A, B, Cin → Sum, Cout), instantiated once as the datapath. The controller holds only registers, the counter (width $clog2(WIDTH)+1), and the FSM.

## Test plan
- WIDTH=8, add 0x5A+0x3C → result 0x96, cout 0, ovf 1; done exactly 9 cycles after start; busy high for exactly 8 cycles.
- Add 0xFF+0x01 → result 0x00, cout 1, ovf 0.
- Sub 0x10−0x20 → result 0xF0, cout 0, ovf 0. Then sub 0x80−0x01 → result 0x7F, cout 1, ovf 1.
- Pulse start with new operands during RUN and during DONE → ignored; the first operation's result is unchanged, and no extra busy or done appears.
- Deassert rst_n mid-RUN (bit 4) → all outputs 0 immediately, asynchronously; no done. After release, a fresh 0x01+0x01 → 0x02.
- Hold start high for 3 back-to-back adds → a done every 10 cycles. result holds the previous value throughout each RUN and updates only at each done.
